// File: rtl/ssfr_pkg.sv
// ssfr_pkg: shared types and constants for the special-function register bank
package ssfr_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT_WAIT} state_t;
  localparam int BEAT_W = 16;
  localparam logic [15:0] SSFR_DEFAULT = 16'h2280;
endpackage

// File: rtl/ssfr_slot.sv
// ssfr_slot: one configuration word with shadow copy, active copy and dirty flag
module ssfr_slot import ssfr_pkg::*; #(
  parameter int REG_W = BEAT_W,
  parameter logic [REG_W-1:0] RESET_VALUE = '0
) (
  input  logic             CLKEXT,
  input  logic             RST_N,
  input  logic             we,
  input  logic [REG_W-1:0] wdata,
  input  logic             commit,
  input  logic             abort,
  output logic [REG_W-1:0] shadow,
  output logic [REG_W-1:0] active,
  output logic             dirty
);
  // abort rolls shadow back; a commit copies the pre-edge shadow while a same-edge write re-dirties it
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      shadow <= RESET_VALUE;
      active <= RESET_VALUE;
      dirty  <= 1'b0;
    end else if (abort) begin
      shadow <= active;
      dirty  <= 1'b0;
    end else begin
      if (commit && dirty) begin
        active <= shadow;
        dirty  <= 1'b0;
      end
      if (we) begin
        shadow <= wdata;
        dirty  <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ssfr_bank.sv
// ssfr_bank: multi-word SFR bank loaded in 16-bit beats, committed atomically when the NPU is idle
module ssfr_bank import ssfr_pkg::*; #(
  parameter int NUM_REGS = 4,
  parameter int REG_W = 16,
  parameter int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  parameter logic [NUM_REGS*REG_W-1:0] RESET_VALUES = {NUM_REGS{REG_W'(SSFR_DEFAULT)}}
) (
  input  logic                      CLKEXT,
  input  logic                      RST_N,
  input  logic [7:0]                DA,
  input  logic [7:0]                DB,
  input  logic                      EN_CONFIG,
  input  logic [ADDR_W-1:0]         CFG_ADDR,
  input  logic                      CFG_COMMIT,
  input  logic                      CFG_ABORT,
  input  logic                      NPU_BUSY,
  input  logic [ADDR_W-1:0]         RD_ADDR,
  input  logic                      RD_SEL,
  output logic [NUM_REGS*REG_W-1:0] SSFR_ACT,
  output logic [REG_W-1:0]          RD_DATA,
  output logic                      CFG_PENDING,
  output logic                      CFG_READY,
  output logic                      CFG_ERR
);
  localparam int BEATS = REG_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);
  state_t state_q, state_d, resume_q, resume_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic err_q, err_d, wr_en, store, commit_go, cfg_ok, rd_ok;
  logic [REG_W-1:0] asm_q, wdata;
  logic [REG_W-1:0] shadow_w [NUM_REGS];
  logic [REG_W-1:0] act_w [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_w;
  assign cfg_ok = {1'b0, CFG_ADDR} < NREG;
  assign rd_ok = {1'b0, RD_ADDR} < NREG;
  assign wdata = (asm_q & ~REG_W'(16'hFFFF)) | REG_W'({DA, DB});
  assign CFG_PENDING = |dirty_w;
  assign CFG_READY = state_q != COMMIT_WAIT;
  assign CFG_ERR = err_q;
  // control state, beat counter, latched address and sticky error
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end
  // beat sequencing and commit arbitration; abort overrides everything
  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    store     = 1'b0;
    commit_go = 1'b0;
    if (CFG_ABORT) begin
      state_d  = IDLE;
      resume_d = IDLE;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else if (state_q == COMMIT_WAIT) begin
      if (EN_CONFIG) err_d = 1'b1;
      if (!NPU_BUSY) begin
        commit_go = 1'b1;
        state_d   = resume_q;
      end
    end else begin
      if (EN_CONFIG) begin
        if (state_q == IDLE) begin
          if (!cfg_ok) err_d = 1'b1;
          else if (BEATS == 1) wr_en = 1'b1;
          else begin
            store   = 1'b1;
            addr_d  = CFG_ADDR;
            cnt_d   = CNT_W'(1);
            state_d = LOAD;
          end
        end else if (CFG_ADDR != addr_q) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(BEATS - 1)) begin
          wr_en   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          store = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (CFG_COMMIT && CFG_PENDING) begin
        if (NPU_BUSY) begin
          resume_d = state_d;
          state_d  = COMMIT_WAIT;
        end else commit_go = 1'b1;
      end
    end
  end
  // assembly buffer: beat k lands in segment BEATS-1-k so the first beat is most significant
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) asm_q <= '0;
    else if (store) asm_q[(BEATS - 1 - int'(cnt_q))*BEAT_W +: BEAT_W] <= {DA, DB};
  end
  // registered readback of the active or shadow word
  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) RD_DATA <= '0;
    else RD_DATA <= rd_ok ? (RD_SEL ? shadow_w[RD_ADDR] : act_w[RD_ADDR]) : '0;
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    ssfr_slot #(.REG_W(REG_W), .RESET_VALUE(RESET_VALUES[i*REG_W +: REG_W])) u_slot (
      .CLKEXT (CLKEXT),
      .RST_N  (RST_N),
      .we     (wr_en && CFG_ADDR == ADDR_W'(i)),
      .wdata  (wdata),
      .commit (commit_go),
      .abort  (CFG_ABORT),
      .shadow (shadow_w[i]),
      .active (act_w[i]),
      .dirty  (dirty_w[i])
    );
    assign SSFR_ACT[i*REG_W +: REG_W] = act_w[i];
  end
endmodule

// File: tb/tb_ssfr_bank.sv
// tb_ssfr_bank: directed checks of a 4x16 bank and a 3x32 bank sharing one stimulus bus
module tb_ssfr_bank;
  logic CLKEXT = 1'b0, RST_N = 1'b0;
  logic [7:0] DA = '0, DB = '0;
  logic EN_CONFIG = 0, CFG_COMMIT = 0, CFG_ABORT = 0, NPU_BUSY = 0, RD_SEL = 0;
  logic [1:0] CFG_ADDR = '0, RD_ADDR = '0;
  logic [63:0] act16;
  logic [15:0] rd16;
  logic pend16, ready16, err16;
  logic [95:0] act32;
  logic [31:0] rd32;
  logic pend32, ready32, err32;
  int vecs = 0, errs = 0;
  localparam logic [15:0] D = 16'h2280;
  localparam logic [31:0] D32 = 32'h0000_2280;

  always #5 CLKEXT = ~CLKEXT;

  ssfr_bank dut16 (
    .CLKEXT(CLKEXT), .RST_N(RST_N), .DA(DA), .DB(DB), .EN_CONFIG(EN_CONFIG),
    .CFG_ADDR(CFG_ADDR), .CFG_COMMIT(CFG_COMMIT), .CFG_ABORT(CFG_ABORT), .NPU_BUSY(NPU_BUSY),
    .RD_ADDR(RD_ADDR), .RD_SEL(RD_SEL), .SSFR_ACT(act16), .RD_DATA(rd16),
    .CFG_PENDING(pend16), .CFG_READY(ready16), .CFG_ERR(err16)
  );

  ssfr_bank #(.NUM_REGS(3), .REG_W(32)) dut32 (
    .CLKEXT(CLKEXT), .RST_N(RST_N), .DA(DA), .DB(DB), .EN_CONFIG(EN_CONFIG),
    .CFG_ADDR(CFG_ADDR), .CFG_COMMIT(CFG_COMMIT), .CFG_ABORT(CFG_ABORT), .NPU_BUSY(NPU_BUSY),
    .RD_ADDR(RD_ADDR), .RD_SEL(RD_SEL), .SSFR_ACT(act32), .RD_DATA(rd32),
    .CFG_PENDING(pend32), .CFG_READY(ready32), .CFG_ERR(err32)
  );

  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic beat(input logic [1:0] a, input logic [15:0] d);
    EN_CONFIG = 1'b1;
    CFG_ADDR = a;
    {DA, DB} = d;
    tick();
    EN_CONFIG = 1'b0;
  endtask

  task automatic rd(input logic sel, input logic [1:0] a);
    RD_SEL = sel;
    RD_ADDR = a;
    tick();
  endtask

  task automatic do_reset();
    {EN_CONFIG, CFG_COMMIT, CFG_ABORT, NPU_BUSY, RD_SEL} = '0;
    RD_ADDR = '0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    beat(2'd1, 16'h4444);
    NPU_BUSY = 1'b1;
    #2 RST_N = 1'b0;
    #2;
    vecs++; if (act16 !== {4{D}}) begin errs++; $display("FAIL reset_act16: got %h want %h", act16, {4{D}}); end
    vecs++; if (act32 !== {3{D32}}) begin errs++; $display("FAIL reset_act32: got %h want %h", act32, {3{D32}}); end
    vecs++; if ({pend16, ready16, err16} !== 3'b010) begin errs++; $display("FAIL reset_flags16: got %b want 010", {pend16, ready16, err16}); end
    vecs++; if ({pend32, ready32, err32} !== 3'b010) begin errs++; $display("FAIL reset_flags32: got %b want 010", {pend32, ready32, err32}); end
    vecs++; if (rd16 !== 16'h0) begin errs++; $display("FAIL reset_rd16: got %h want 0000", rd16); end
    NPU_BUSY = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_write_commit();
    do_reset();
    beat(2'd2, 16'h1234);
    vecs++; if (pend16 !== 1'b1) begin errs++; $display("FAIL wc_pending_set: got %b want 1", pend16); end
    vecs++; if (act16 !== {4{D}}) begin errs++; $display("FAIL wc_act_before: got %h want %h", act16, {4{D}}); end
    rd(1'b1, 2'd2);
    vecs++; if (rd16 !== 16'h1234) begin errs++; $display("FAIL wc_shadow_rd: got %h want 1234", rd16); end
    CFG_COMMIT = 1'b1;
    tick();
    CFG_COMMIT = 1'b0;
    vecs++; if (act16 !== {D, 16'h1234, D, D}) begin errs++; $display("FAIL wc_act_after: got %h want %h", act16, {D, 16'h1234, D, D}); end
    vecs++; if (pend16 !== 1'b0) begin errs++; $display("FAIL wc_pending_clr: got %b want 0", pend16); end
    rd(1'b0, 2'd2);
    vecs++; if (rd16 !== 16'h1234) begin errs++; $display("FAIL wc_active_rd: got %h want 1234", rd16); end
    NPU_BUSY = 1'b1;
    CFG_COMMIT = 1'b1;
    tick();
    {NPU_BUSY, CFG_COMMIT} = '0;
    vecs++; if (ready16 !== 1'b1) begin errs++; $display("FAIL wc_clean_commit_ready: got %b want 1", ready16); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    beat(2'd0, 16'h1111);
    CFG_COMMIT = 1'b1;
    beat(2'd1, 16'h2222);
    CFG_COMMIT = 1'b0;
    vecs++; if (act16 !== {D, D, D, 16'h1111}) begin errs++; $display("FAIL b2b_act: got %h want %h", act16, {D, D, D, 16'h1111}); end
    vecs++; if (pend16 !== 1'b1) begin errs++; $display("FAIL b2b_pending: got %b want 1", pend16); end
    CFG_COMMIT = 1'b1;
    tick();
    CFG_COMMIT = 1'b0;
    vecs++; if (act16 !== {D, D, 16'h2222, 16'h1111}) begin errs++; $display("FAIL b2b_act2: got %h want %h", act16, {D, D, 16'h2222, 16'h1111}); end
  endtask

  task automatic test_multi_beat();
    do_reset();
    beat(2'd1, 16'hDEAD);
    vecs++; if (pend32 !== 1'b0) begin errs++; $display("FAIL mb_pending_mid: got %b want 0", pend32); end
    beat(2'd1, 16'hBEEF);
    vecs++; if (pend32 !== 1'b1) begin errs++; $display("FAIL mb_pending: got %b want 1", pend32); end
    rd(1'b1, 2'd1);
    vecs++; if (rd32 !== 32'hDEADBEEF) begin errs++; $display("FAIL mb_shadow: got %h want deadbeef", rd32); end
    beat(2'd0, 16'h1111);
    beat(2'd2, 16'h2222);
    vecs++; if (err32 !== 1'b1) begin errs++; $display("FAIL mb_addr_change_err: got %b want 1", err32); end
    rd(1'b1, 2'd0);
    vecs++; if (rd32 !== D32) begin errs++; $display("FAIL mb_drop0: got %h want %h", rd32, D32); end
    rd(1'b1, 2'd2);
    vecs++; if (rd32 !== D32) begin errs++; $display("FAIL mb_drop2: got %h want %h", rd32, D32); end
    vecs++; if (act32 !== {3{D32}}) begin errs++; $display("FAIL mb_act: got %h want %h", act32, {3{D32}}); end
    CFG_ABORT = 1'b1;
    tick();
    CFG_ABORT = 1'b0;
    vecs++; if ({err32, pend32} !== 2'b00) begin errs++; $display("FAIL mb_abort: got %b want 00", {err32, pend32}); end
    beat(2'd3, 16'h5555);
    vecs++; if ({err32, ready32, pend32} !== 3'b110) begin errs++; $display("FAIL mb_bad_addr: got %b want 110", {err32, ready32, pend32}); end
    rd(1'b1, 2'd3);
    vecs++; if (rd32 !== 32'h0) begin errs++; $display("FAIL mb_rd_oob: got %h want 0", rd32); end
  endtask

  task automatic test_busy();
    do_reset();
    beat(2'd1, 16'hABCD);
    NPU_BUSY = 1'b1;
    CFG_COMMIT = 1'b1;
    tick();
    CFG_COMMIT = 1'b0;
    vecs++; if (ready16 !== 1'b0) begin errs++; $display("FAIL busy_ready: got %b want 0", ready16); end
    for (int i = 0; i < 4; i++) begin
      EN_CONFIG = (i == 1);
      CFG_ADDR = 2'd0;
      {DA, DB} = 16'h5555;
      tick();
      vecs++; if (act16 !== {4{D}} || ready16 !== 1'b0) begin errs++; $display("FAIL busy_hold%0d: act %h ready %b want %h ready 0", i, act16, ready16, {4{D}}); end
    end
    EN_CONFIG = 1'b0;
    vecs++; if (err16 !== 1'b1) begin errs++; $display("FAIL busy_en_err: got %b want 1", err16); end
    NPU_BUSY = 1'b0;
    tick();
    vecs++; if (act16 !== {D, D, 16'hABCD, D}) begin errs++; $display("FAIL busy_release: got %h want %h", act16, {D, D, 16'hABCD, D}); end
    vecs++; if ({ready16, pend16} !== 2'b10) begin errs++; $display("FAIL busy_flags: got %b want 10", {ready16, pend16}); end
    rd(1'b1, 2'd0);
    vecs++; if (rd16 !== D) begin errs++; $display("FAIL busy_ignored_beat: got %h want %h", rd16, D); end
  endtask

  task automatic test_abort();
    do_reset();
    beat(2'd0, 16'hAAAA);
    CFG_ABORT = 1'b1;
    CFG_COMMIT = 1'b1;
    tick();
    {CFG_ABORT, CFG_COMMIT} = '0;
    vecs++; if (act16 !== {4{D}} || pend16 !== 1'b0) begin errs++; $display("FAIL abort_act: got %h pend %b want %h pend 0", act16, pend16, {4{D}}); end
    rd(1'b1, 2'd0);
    vecs++; if (rd16 !== D) begin errs++; $display("FAIL abort_shadow: got %h want %h", rd16, D); end
    beat(2'd0, 16'hAAAA);
    NPU_BUSY = 1'b1;
    CFG_COMMIT = 1'b1;
    tick();
    CFG_COMMIT = 1'b0;
    beat(2'd0, 16'h7777);
    vecs++; if (err16 !== 1'b1) begin errs++; $display("FAIL abort_pre_err: got %b want 1", err16); end
    {CFG_ABORT, CFG_COMMIT, NPU_BUSY} = 3'b110;
    tick();
    {CFG_ABORT, CFG_COMMIT} = '0;
    vecs++; if (act16 !== {4{D}}) begin errs++; $display("FAIL abort_wait_act: got %h want %h", act16, {4{D}}); end
    vecs++; if ({err16, ready16, pend16} !== 3'b010) begin errs++; $display("FAIL abort_wait_flags: got %b want 010", {err16, ready16, pend16}); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    beat(2'd2, 16'h1234);
    #2 RST_N = 1'b0;
    #1;
    vecs++; if (act32 !== {3{D32}} || {pend32, ready32, err32} !== 3'b010 || rd32 !== 32'h0) begin errs++; $display("FAIL rml_async: act %h flags %b rd %h", act32, {pend32, ready32, err32}, rd32); end
    tick();
    RST_N = 1'b1;
    tick();
    beat(2'd2, 16'h0102);
    beat(2'd2, 16'h0304);
    CFG_COMMIT = 1'b1;
    tick();
    CFG_COMMIT = 1'b0;
    vecs++; if (act32 !== {32'h01020304, D32, D32}) begin errs++; $display("FAIL rml_reload: got %h want %h", act32, {32'h01020304, D32, D32}); end
    vecs++; if ({pend32, err32} !== 2'b00) begin errs++; $display("FAIL rml_flags: got %b want 00", {pend32, err32}); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_back_to_back();
    test_multi_beat();
    test_busy();
    test_abort();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ssfr_bank.md
# ssfr_bank

Parametrised special-function register bank for the NPU: holds NUM_REGS configuration words of REG_W bits, loaded from the 8-bit DA/DB configuration bus as one or more 16-bit beats. Writes land in shadow registers and are applied atomically to the active outputs on commit, deferred while the NPU is busy. It sits between the external configuration loader and the NPU datapath/control, and supersedes the single fixed 16-bit SSFR.

## Interface
- NUM_REGS, 4, number of configuration words (≥1)
- REG_W, 16, bits per word; multiple of 16; BEATS = REG_W/16
- ADDR_W, $clog2(NUM_REGS) (min 1), CFG_ADDR/RD_ADDR width
- RESET_VALUES, {NUM_REGS{REG_W'(16'h2280)}}, flat NUM_REGS*REG_W reset image; word i at [i*REG_W +: REG_W]

Ports:
- CLKEXT  in  1  single clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- DA  in  8  beat high byte
- DB  in  8  beat low byte
- EN_CONFIG  in  1  beat strobe; {DA,DB} captured on the edge where high
- CFG_ADDR  in  ADDR_W  target word; sampled with EN_CONFIG
- CFG_COMMIT  in  1  request copy of dirty shadows to active
- CFG_ABORT  in  1  discard partial load and all dirty shadows, clear CFG_ERR
- NPU_BUSY  in  1  NPU running; blocks commit application
- RD_ADDR  in  ADDR_W  readback word select
- RD_SEL  in  1  0 = active, 1 = shadow
- SSFR_ACT  out  NUM_REGS*REG_W  active configuration to NPU
- RD_DATA  out  REG_W  registered readback
- CFG_PENDING  out  1  OR of dirty bits
- CFG_READY  out  1  high when EN_CONFIG is accepted (not COMMIT_WAIT)
- CFG_ERR  out  1  sticky protocol error

## Operation
- Reset: active and shadow = RESET_VALUES, dirty = 0, beat counter = 0, state IDLE, CFG_ERR = 0, RD_DATA = 0, CFG_READY = 1.
- Beat order: first beat is most significant 16 bits; word = {beat0, beat1, …}.
- States: IDLE, LOAD, COMMIT_WAIT.
- IDLE: EN_CONFIG with valid CFG_ADDR latches address and beat0; BEATS=1 → shadow written, dirty set, stay IDLE; else → LOAD, count=1.
- LOAD: each EN_CONFIG stores next beat; on last beat write shadow, set dirty, → IDLE. CFG_ADDR differing from latched address → CFG_ERR, beat dropped, partial load discarded, → IDLE.
- CFG_ADDR ≥ NUM_REGS with EN_CONFIG → CFG_ERR, no write.
- CFG_COMMIT in IDLE/LOAD: NPU_BUSY=0 → every dirty word copied to active at that edge, its dirty cleared; NPU_BUSY=1 → COMMIT_WAIT, which resumes prior state (IDLE; LOAD partial preserved) and applies on the first edge with NPU_BUSY=0.
- COMMIT_WAIT: EN_CONFIG ignored and sets CFG_ERR; CFG_READY = 0.
- CFG_ABORT (any state): partial load dropped, shadow := active, dirty = 0, CFG_ERR = 0, → IDLE; abort wins over simultaneous COMMIT/EN_CONFIG.
- Commit and final-beat write on same edge: commit uses pre-edge shadow; the newly written word stays dirty.
- CFG_COMMIT with dirty = 0: no effect, no state change.

## Timing
- Shadow update: visible in RD_DATA (RD_SEL=1) 2 edges after the final beat edge (write edge + readback register).
- Commit: SSFR_ACT changes on the edge sampling CFG_COMMIT=1, NPU_BUSY=0 (0 added latency); in COMMIT_WAIT, on the first edge with NPU_BUSY=0.
- SSFR_ACT never changes while NPU_BUSY=1 except via reset.
- RD_DATA: 1-cycle registered latency from RD_ADDR/RD_SEL; RD_ADDR ≥ NUM_REGS returns 0.
- CFG_PENDING, CFG_READY, CFG_ERR are registered-state decodes, valid the cycle after the causing edge.
- Reset assertion mid-load or in COMMIT_WAIT: immediate return to reset values, no partial commit.

## Structure
- Package ssfr_pkg: state enum (IDLE, LOAD, COMMIT_WAIT), BEAT_W = 16, SSFR_DEFAULT = 16'h2280.
- Sub-module ssfr_slot (one per word, generate loop): shadow, active, dirty; inputs write-enable/data, commit, abort.
- Top holds FSM, beat counter, assembly buffer, error flag, readback mux.

## Test plan
- Reset with NUM_REGS=4, REG_W=16 → every SSFR_ACT word = 16'h2280, CFG_PENDING=0, CFG_READY=1.
- Write addr 2 {DA,DB}={8'h12,8'h34}, commit with NPU_BUSY=0 → word 2 = 16'h1234 at commit edge; others unchanged; CFG_PENDING → 0.
- REG_W=32: beats 16'hDEAD then 16'hBEEF to addr 1 → shadow 32'hDEADBEEF; address change between beats → CFG_ERR=1, shadow unchanged.
- Commit with NPU_BUSY=1 for 5 cycles → SSFR_ACT stable, CFG_READY=0, EN_CONFIG sets CFG_ERR; update on first edge after BUSY drops.
- Write 16'hAAAA to addr 0, CFG_ABORT with CFG_COMMIT same cycle → active stays 16'h2280, shadow readback 16'h2280, CFG_ERR=0.
- Assert RST_N low during LOAD beat 1 of 2 → all outputs at reset values asynchronously; next full load completes normally.
